rbm_gibbs_scheduler: RTL and testbench
======================================

# rbm_gibbs_scheduler

- Sequences one up-layer instance (visible→hidden) and one down-layer instance (hidden→visible) through K contrastive-divergence Gibbs steps.
- Per pass: pulses the layer's reset, holds the layer's `data_valid` until the layer's `finish`, then latches the sampled vector and routes it to the other layer.
- Sits between the host/training loop and the two layer instances; owns per-job random-generator reseeding.

## Interface
Parameters:
- `VIS_DIM`, 15, visible vector width
- `HID_DIM`, 5, hidden vector width
- `STEP_W`, 8, width of step count
- `TIMEOUT`, 1023, max cycles a pass waits for `finish` (≥1)

Ports:
- `clock`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  job request, sampled in IDLE only
- `num_steps`  in  STEP_W  K, number of Gibbs steps, latched on accepted start
- `vis_in`  in  VIS_DIM  initial visible vector, latched on accepted start
- `busy`  out  1  high from accepted start through DONE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  set on timeout, cleared on next accepted start
- `vis_out`  out  VIS_DIM  current visible register
- `hid_out`  out  HID_DIM  current hidden register
- `step_cnt`  out  STEP_W  completed Gibbs steps
- `rand_reset`  out  1  one-cycle reseed pulse to both layers' random generators
- `h_reset`, `h_valid`  out  1 each  up-layer reset / data_valid
- `h_in`  out  VIS_DIM  = `vis_out`
- `h_out`  in  HID_DIM  up-layer samples
- `h_finish`  in  1  up-layer finish
- `v_reset`, `v_valid`  out  1 each  down-layer reset / data_valid
- `v_in`  out  HID_DIM  = `hid_out`
- `v_out`  in  VIS_DIM  down-layer samples
- `v_finish`  in  1  down-layer finish

## Operation
- States: IDLE, H_RST, H_RUN, V_RST, V_RUN, DONE.
- IDLE, `start`=1:
  - latch `vis_in`→vis reg, `num_steps`→K
  - clear `step_cnt`, `err`
  - pulse `rand_reset`
  - → H_RST
  - `start` outside IDLE is ignored, not queued.
- H_RST: `h_reset`=1 for exactly one cycle → H_RUN.
- H_RUN:
  - `h_valid`=1; `h_finish` is ignored on the first H_RUN cycle.
  - Thereafter, on `h_finish`=1: hid reg ← `h_out`. If `step_cnt`==K → DONE, else → V_RST.
- V_RST: `v_reset`=1 for one cycle → V_RUN.
- V_RUN: `v_valid`=1; on `v_finish`=1 (same first-cycle rule): vis reg ← `v_out`, `step_cnt`+1 → H_RST.
- DONE: `done`=1 for one cycle → IDLE.
- Pass sequence is up, (down, up)×K. K=0 gives a single up pass; K=255 gives 511 passes.
- `step_cnt` never wraps: it stops at K ≤ 2^STEP_W−1.
- Timeout:
  - Phase timer reloads on entry to H_RUN/V_RUN.
  - If `finish` is not seen within TIMEOUT cycles: set `err`, leave vis/hid regs unchanged, → DONE.
- `h_reset`/`v_reset` are also asserted combinationally while `reset`=1, so the layers are cleared with the controller.
- `h_valid`/`v_valid` are never both high. `h_in`/`v_in` are stable for the whole RUN state.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `rand_reset`, `h_valid`, `v_valid` = 0; `vis_out`, `hid_out`, `step_cnt` = 0; `h_reset`/`v_reset` = 1 while `reset` is held.
- Start→`h_reset`: the start edge enters H_RST, and `h_reset` is high the following cycle.
- Each pass costs 1 (RST) + F cycles, where F is the number of RUN cycles up to and including the `finish` cycle.
- `done` rises 1 cycle after the final `h_finish`. `busy` falls with `done`.
- Outputs are registered, except `h_in`/`v_in`, which are direct register copies, and the reset ORing on `h_reset`/`v_reset`.
- Reset mid-job: immediate return to IDLE, all outputs cleared, no `done` pulse.
- `finish` and timeout expiry in the same cycle: `finish` wins, and `err` is not set.

## Structure
- Package `rbm_ctrl_pkg` holds:
  - state enum encoding
  - `STEP_W` default
  - `TIMEOUT` default
- Sub-module `rbm_phase_timer`: loadable down-counter with an `expired` flag, one instance shared by both RUN states.

## Test plan
Benches use stub layers that assert `finish` F cycles after reset deasserts and return fixed patterns.

1. K=0, `vis_in`=15'h1234, F=6, `h_out`=5'b10110 → one `h_reset` pulse, no `v_valid` ever; `hid_out`=5'b10110; `done` 8 cycles after start; `step_cnt`=0.
2. K=3, F=4 → pass order H,V,H,V,H,V,H; `step_cnt` 1,2,3; `done` once; total 1+7×5+1 cycles to DONE exit; `rand_reset` exactly once.
3. Up stub never finishes, TIMEOUT=20 → `err`=1, `done` pulse ~22 cycles after start, regs unchanged; next start clears `err`.
4. `reset` asserted during V_RUN of step 2 → all outputs 0 and `h_reset`/`v_reset` high in the same cycle; no `done`; fresh start works normally.
5. `start` held high through a job → exactly one job runs per IDLE visit; mid-job `vis_in` changes are ignored.
6. Stub finishes on the first RUN cycle (stale finish) → ignored; the pass completes on the next `finish`, and `h_valid`/`v_valid` are never both high.

Source files
------------

// File: rtl/rbm_ctrl_pkg.sv
// Shared definitions for the RBM Gibbs-sampling controller: state encoding
// and default sizing for the step counter and per-pass timeout.
package rbm_ctrl_pkg;

    localparam int STEP_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_H_RST = 3'd1,
        S_H_RUN = 3'd2,
        S_V_RST = 3'd3,
        S_V_RUN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/rbm_phase_timer.sv
// Loadable down-counter guarding a single layer pass. Loaded to TIMEOUT as
// the pass enters its RUN state; expired_o marks the TIMEOUT-th RUN cycle.
module rbm_phase_timer
    import rbm_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload wins over counting; the counter parks at zero rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(TIMEOUT);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CW'(1));

endmodule

// File: rtl/rbm_gibbs_scheduler.sv
// Contrastive-divergence Gibbs-step sequencer. Runs an up pass (visible to
// hidden), then K rounds of down/up passes, moving the sampled vectors
// between the two layer instances and reseeding their RNGs once per job.
module rbm_gibbs_scheduler
    import rbm_ctrl_pkg::*;
#(
    parameter int VIS_DIM = 15,
    parameter int HID_DIM = 5,
    parameter int STEP_W  = STEP_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic [VIS_DIM-1:0] vis_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [VIS_DIM-1:0] vis_out,
    output logic [HID_DIM-1:0] hid_out,
    output logic [STEP_W-1:0]  step_cnt,
    output logic               rand_reset,
    output logic               h_reset,
    output logic               h_valid,
    output logic [VIS_DIM-1:0] h_in,
    input  logic [HID_DIM-1:0] h_out,
    input  logic               h_finish,
    output logic               v_reset,
    output logic               v_valid,
    output logic [HID_DIM-1:0] v_in,
    input  logic [VIS_DIM-1:0] v_out,
    input  logic               v_finish
);

    state_t             state_q, state_d;
    logic [VIS_DIM-1:0] vis_q, vis_d;
    logic [HID_DIM-1:0] hid_q, hid_d;
    logic [STEP_W-1:0]  k_q, k_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               err_q, err_d;
    logic               first_q, first_d;
    logic               rand_d;
    logic               busy_q, done_q, rand_q;
    logic               h_reset_q, h_valid_q, v_reset_q, v_valid_q;
    logic               tmr_load, tmr_en, tmr_expired;

    rbm_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state and datapath-update logic; a finish on the first RUN cycle is
    // stale (left over from the previous pass) and finish beats timeout.
    always_comb begin
        state_d  = state_q;
        vis_d    = vis_q;
        hid_d    = hid_q;
        k_d      = k_q;
        step_d   = step_q;
        err_d    = err_q;
        first_d  = 1'b0;
        rand_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vis_d   = vis_in;
                    k_d     = num_steps;
                    step_d  = '0;
                    err_d   = 1'b0;
                    rand_d  = 1'b1;
                    state_d = S_H_RST;
                end
            end
            S_H_RST: begin
                tmr_load = 1'b1;
                first_d  = 1'b1;
                state_d  = S_H_RUN;
            end
            S_H_RUN: begin
                tmr_en = 1'b1;
                if (h_finish && !first_q) begin
                    hid_d   = h_out;
                    state_d = (step_q == k_q) ? S_DONE : S_V_RST;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_V_RST: begin
                tmr_load = 1'b1;
                first_d  = 1'b1;
                state_d  = S_V_RUN;
            end
            S_V_RUN: begin
                tmr_en = 1'b1;
                if (v_finish && !first_q) begin
                    vis_d   = v_out;
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_H_RST;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, vectors and counters; async reset returns everything to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vis_q   <= '0;
            hid_q   <= '0;
            k_q     <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vis_q   <= vis_d;
            hid_q   <= hid_d;
            k_q     <= k_d;
            step_q  <= step_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    // Registered control outputs decoded from the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rand_q    <= 1'b0;
            h_reset_q <= 1'b0;
            h_valid_q <= 1'b0;
            v_reset_q <= 1'b0;
            v_valid_q <= 1'b0;
        end else begin
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            rand_q    <= rand_d;
            h_reset_q <= (state_d == S_H_RST);
            h_valid_q <= (state_d == S_H_RUN);
            v_reset_q <= (state_d == S_V_RST);
            v_valid_q <= (state_d == S_V_RUN);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rand_reset = rand_q;
    assign vis_out    = vis_q;
    assign hid_out    = hid_q;
    assign step_cnt   = step_q;
    assign h_reset    = h_reset_q | reset;
    assign v_reset    = v_reset_q | reset;
    assign h_valid    = h_valid_q;
    assign v_valid    = v_valid_q;
    assign h_in       = vis_q;
    assign v_in       = hid_q;

endmodule

// File: tb/tb_rbm_gibbs_scheduler.sv
// Bench for rbm_gibbs_scheduler with stub layers and a vector-level model of
// the Gibbs chain.
module tb_rbm_gibbs_scheduler;

    localparam int VD = 15;
    localparam int HD = 5;
    localparam int SW = 8;
    localparam int TO = 20;
    localparam int BOUND = 4000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [SW-1:0] num_steps;
    logic [VD-1:0] vis_in;
    logic          busy, done, err, rand_reset;
    logic [VD-1:0] vis_out, h_in, v_out;
    logic [HD-1:0] hid_out, v_in, h_out;
    logic [SW-1:0] step_cnt;
    logic          h_reset, h_valid, h_finish;
    logic          v_reset, v_valid, v_finish;

    rbm_gibbs_scheduler #(.VIS_DIM(VD), .HID_DIM(HD), .STEP_W(SW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .num_steps(num_steps),
        .vis_in(vis_in), .busy(busy), .done(done), .err(err),
        .vis_out(vis_out), .hid_out(hid_out), .step_cnt(step_cnt),
        .rand_reset(rand_reset),
        .h_reset(h_reset), .h_valid(h_valid), .h_in(h_in), .h_out(h_out), .h_finish(h_finish),
        .v_reset(v_reset), .v_valid(v_valid), .v_in(v_in), .v_out(v_out), .v_finish(v_finish)
    );

    always #5 clock = ~clock;

    // Stub layer behaviour: samples are a fixed function of the layer input.
    function automatic logic [HD-1:0] fh(input logic [VD-1:0] v);
        return v[4:0] ^ v[9:5] ^ v[14:10] ^ 5'h0b;
    endfunction

    function automatic logic [VD-1:0] fv(input logic [HD-1:0] h);
        return {h, ~h, h ^ 5'h15};
    endfunction

    logic          h_en = 1'b1, v_en = 1'b1, stale = 1'b0, hfix_en = 1'b0;
    logic [HD-1:0] hfix = '0;
    int            f_cfg = 4;
    int            h_cnt = 0, v_cnt = 0;

    always @(posedge clock) begin
        if (h_reset) h_cnt <= 0;
        else if (h_valid) h_cnt <= h_cnt + 1;
    end
    always @(posedge clock) begin
        if (v_reset) v_cnt <= 0;
        else if (v_valid) v_cnt <= v_cnt + 1;
    end

    assign h_finish = h_en && h_valid && ((h_cnt == f_cfg - 1) || (stale && h_cnt == 0));
    assign v_finish = v_en && v_valid && ((v_cnt == f_cfg - 1) || (stale && v_cnt == 0));
    assign h_out    = hfix_en ? hfix : fh(h_in);
    assign v_out    = fv(v_in);

    int hr_n = 0, vr_n = 0, rr_n = 0, dn_n = 0, both_n = 0;
    always @(posedge clock) begin
        if (!reset) begin
            if (h_reset)            hr_n   <= hr_n + 1;
            if (v_reset)            vr_n   <= vr_n + 1;
            if (rand_reset)         rr_n   <= rr_n + 1;
            if (done)               dn_n   <= dn_n + 1;
            if (h_valid && v_valid) both_n <= both_n + 1;
        end
    end

    int pass_n = 0, total_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Chain model: up pass, then K rounds of (down, up).
    function automatic void model(input logic [VD-1:0] v0, input int k, input logic hfe,
                                  input logic [HD-1:0] hf,
                                  output logic [VD-1:0] ve, output logic [HD-1:0] he);
        logic [VD-1:0] v;
        logic [HD-1:0] h;
        v = v0;
        h = hfe ? hf : fh(v);
        for (int i = 0; i < k; i++) begin
            v = fv(h);
            h = hfe ? hf : fh(v);
        end
        ve = v;
        he = h;
    endfunction

    typedef struct {
        int            k;
        logic [VD-1:0] vis;
        int            f;
        logic          st;
        logic          hfe;
        logic [HD-1:0] hf;
        int            ecyc;
        logic [VD-1:0] evis;
        logic [HD-1:0] ehid;
    } vec_t;

    function automatic vec_t mk(input int k, input logic [VD-1:0] vis, input int f, input logic st);
        vec_t t;
        t.k = k; t.vis = vis; t.f = f; t.st = st; t.hfe = 1'b0; t.hf = '0;
        t.ecyc = (2 * k + 1) * (f + 1) + 1;
        model(vis, k, 1'b0, '0, t.evis, t.ehid);
        return t;
    endfunction

    vec_t tbl[$];

    task automatic run_vec(input vec_t t, input string nm);
        int n, hr0, vr0, rr0, dn0;
        logic got;
        f_cfg = t.f; stale = t.st; hfix_en = t.hfe; hfix = t.hf; h_en = 1'b1; v_en = 1'b1;
        @(negedge clock);
        hr0 = hr_n; vr0 = vr_n; rr0 = rr_n; dn0 = dn_n;
        start = 1'b1; num_steps = SW'(t.k); vis_in = t.vis;
        n = 0; got = 1'b0;
        while (n < BOUND) begin
            @(posedge clock); n++; #1;
            if (n == 1) begin
                chk({nm, "_hreset_after_start"}, h_reset, 1);
                chk({nm, "_rand_after_start"}, rand_reset, 1);
                chk({nm, "_err_cleared"}, err, 0);
            end
            start = 1'b0; vis_in = VD'($urandom); num_steps = SW'($urandom);
            if (done) begin got = 1'b1; break; end
        end
        chk({nm, "_done_seen"}, got, 1);
        chk({nm, "_cycles"}, n, t.ecyc);
        chk({nm, "_vis"}, vis_out, t.evis);
        chk({nm, "_hid"}, hid_out, t.ehid);
        chk({nm, "_step"}, step_cnt, t.k);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_busy_in_done"}, busy, 1);
        chk({nm, "_h_passes"}, hr_n - hr0, t.k + 1);
        chk({nm, "_v_passes"}, vr_n - vr0, t.k);
        chk({nm, "_rand_once"}, rr_n - rr0, 1);
        @(posedge clock); #1;
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_done_count"}, dn_n - dn0, 1);
    endtask

    initial begin
        int n;
        logic got;
        logic [VD-1:0] ev, va, vb;
        logic [HD-1:0] eh, hprev;
        int rr0, dn0;

        reset = 1'b1; start = 1'b0; num_steps = '0; vis_in = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_err", err, 0);     chk("rst_rand", rand_reset, 0);
        chk("rst_hval", h_valid, 0); chk("rst_vval", v_valid, 0);
        chk("rst_vis", vis_out, 0); chk("rst_hid", hid_out, 0);
        chk("rst_step", step_cnt, 0);
        chk("rst_hreset", h_reset, 1); chk("rst_vreset", v_reset, 1);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_hreset", h_reset, 0); chk("idle_busy", busy, 0);

        // Directed vectors; first entry is fully hand-computed.
        tbl.push_back('{0, 15'h1234, 6, 1'b0, 1'b1, 5'b10110, 8, 15'h1234, 5'b10110});
        tbl.push_back(mk(3, 15'h5a5a, 4, 1'b0));
        tbl.push_back(mk(1, 15'h7fff, 2, 1'b1));
        tbl.push_back(mk(2, 15'h0001, 3, 1'b1));
        tbl.push_back(mk(5, 15'h2c3d, 7, 1'b0));
        tbl.push_back(mk(0, 15'h0000, 19, 1'b1));
        tbl.push_back(mk(255, 15'h4321, 2, 1'b0));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++)
            run_vec(mk($urandom_range(0, 10), VD'($urandom), $urandom_range(2, 15),
                       1'($urandom_range(0, 1))), $sformatf("rnd%0d", i));

        // Up layer never finishes: timeout after TO RUN cycles.
        h_en = 1'b0; stale = 1'b0; hfix_en = 1'b0; f_cfg = 4;
        hprev = hid_out;
        @(negedge clock);
        start = 1'b1; num_steps = 8'd2; vis_in = 15'h3a5c;
        n = 0; got = 1'b0;
        while (n < 200) begin
            @(posedge clock); n++; #1; start = 1'b0; vis_in = VD'($urandom);
            if (done) begin got = 1'b1; break; end
        end
        chk("to_done_seen", got, 1);
        chk("to_cycles", n, TO + 2);
        chk("to_err", err, 1);
        chk("to_vis", vis_out, 15'h3a5c);
        chk("to_hid", hid_out, hprev);
        chk("to_step", step_cnt, 0);
        @(posedge clock); #1;
        chk("to_err_held", err, 1);
        h_en = 1'b1;
        run_vec(mk(1, 15'h1111, 3, 1'b0), "after_to");

        // Reset during the second step's down pass.
        f_cfg = 4; stale = 1'b0;
        @(negedge clock);
        start = 1'b1; num_steps = 8'd3; vis_in = 15'h6b6b;
        n = 0; got = 1'b0;
        while (n < 500) begin
            @(posedge clock); n++; #1; start = 1'b0;
            if (v_valid && step_cnt == 8'd1) begin got = 1'b1; break; end
        end
        chk("mid_reached_vrun2", got, 1);
        dn0 = dn_n;
        reset = 1'b1; #1;
        chk("mid_busy", busy, 0);   chk("mid_done", done, 0);
        chk("mid_vval", v_valid, 0); chk("mid_hval", h_valid, 0);
        chk("mid_vis", vis_out, 0); chk("mid_hid", hid_out, 0);
        chk("mid_step", step_cnt, 0);
        chk("mid_hreset", h_reset, 1); chk("mid_vreset", v_reset, 1);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        repeat (5) @(posedge clock); #1;
        chk("mid_no_done", dn_n - dn0, 0);
        chk("mid_idle", busy, 0);
        run_vec(mk(2, 15'h0f0f, 5, 1'b0), "after_rst");

        // Start held high: one job per IDLE visit, mid-job vis_in ignored.
        f_cfg = 3; stale = 1'b0; hfix_en = 1'b0;
        va = 15'h2468; vb = 15'h1357;
        @(negedge clock);
        rr0 = rr_n;
        start = 1'b1; num_steps = 8'd1; vis_in = va;
        n = 0; got = 1'b0;
        while (n < 200) begin
            @(posedge clock); n++; #1; vis_in = VD'($urandom);
            if (done) begin got = 1'b1; break; end
        end
        model(va, 1, 1'b0, '0, ev, eh);
        chk("hold_done_seen", got, 1);
        chk("hold_cycles", n, 13);
        chk("hold_vis", vis_out, ev);
        chk("hold_hid", hid_out, eh);
        vis_in = vb; num_steps = 8'd0;
        @(posedge clock); #1;
        chk("hold_idle_gap", busy, 0);
        chk("hold_no_rand_in_idle", rand_reset, 0);
        @(posedge clock); #1;
        chk("hold_reaccept", busy, 1);
        chk("hold_rand2", rand_reset, 1);
        start = 1'b0;
        n = 1; got = 1'b0;
        while (n < 200) begin
            @(posedge clock); n++; #1; vis_in = VD'($urandom);
            if (done) begin got = 1'b1; break; end
        end
        chk("hold2_done_seen", got, 1);
        chk("hold2_cycles", n, 5);
        chk("hold2_vis", vis_out, vb);
        chk("hold2_hid", hid_out, fh(vb));
        @(posedge clock); #1;
        chk("hold_rand_total", rr_n - rr0, 2);

        chk("never_both_valid", both_n, 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
